// File: rtl/button_repeat_n.sv
// Multi-channel button front end: 2-FF sync, sampled debounce, press/release edges,
// typematic auto-repeat (delay, slow, fast phases) and a one-shot long-press event.
module button_repeat_n #(
    parameter int unsigned N_BTN       = 7,
    parameter int unsigned CLK_HZ      = 100_000_000,
    parameter int unsigned SAMPLE_HZ   = 1000,
    parameter int unsigned DB_SAMPLES  = 4,
    parameter int unsigned DELAY_TICKS = 400,
    parameter int unsigned SLOW_TICKS  = 100,
    parameter int unsigned FAST_AFTER  = 8,
    parameter int unsigned FAST_TICKS  = 25,
    parameter int unsigned LONG_TICKS  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_BTN-1:0] btn_n,
    output logic [N_BTN-1:0] pressed,
    output logic [N_BTN-1:0] press_pulse,
    output logic [N_BTN-1:0] release_pulse,
    output logic [N_BTN-1:0] repeat_pulse,
    output logic [N_BTN-1:0] long_pulse,
    output logic             any_pressed
);

    localparam int unsigned DIV   = (CLK_HZ / SAMPLE_HZ < 1) ? 1 : CLK_HZ / SAMPLE_HZ;
    localparam int unsigned DIV_W = $clog2(DIV) + 1;
    localparam int unsigned MAX_A = (DELAY_TICKS > SLOW_TICKS) ? DELAY_TICKS : SLOW_TICKS;
    localparam int unsigned MAX_B = (FAST_TICKS > LONG_TICKS) ? FAST_TICKS : LONG_TICKS;
    localparam int unsigned MAX_T = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int unsigned TW    = $clog2(MAX_T) + 1;
    localparam int unsigned DBW   = $clog2(DB_SAMPLES) + 1;
    localparam int unsigned RW    = $clog2(FAST_AFTER) + 1;

    typedef enum logic [1:0] {StIdle, StDelay, StSlow, StFast} state_e;

    logic [DIV_W-1:0] div_q;
    logic             sample_tick;
    logic [N_BTN-1:0] sync1_q, sync2_q;
    logic [N_BTN-1:0] pressed_nx;

    assign sample_tick = (div_q == DIV_W'(DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q       <= '0;
            sync1_q     <= '1;
            sync2_q     <= '1;
            any_pressed <= 1'b0;
        end else begin
            div_q       <= sample_tick ? '0 : div_q + 1'b1;
            sync1_q     <= btn_n;
            sync2_q     <= sync1_q;
            any_pressed <= |pressed_nx;
        end
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_ch
        state_e         state_q, state_d;
        logic [DBW-1:0] db_q, db_d;
        logic [TW-1:0]  tcnt_q, tcnt_d, tnext;
        logic [TW-1:0]  age_q, age_d;
        logic [RW-1:0]  rcnt_q, rcnt_d, rnext;
        logic           long_done_q, long_done_d;
        logic           pressed_q, pressed_d;
        logic           pp_q, pp_d, rp_q, rp_d, rep_q, rep_d, lp_q, lp_d;
        logic           toggle;
        logic           samp;

        assign samp  = ~sync2_q[i];
        assign tnext = tcnt_q + 1'b1;
        assign rnext = rcnt_q + 1'b1;

        always_comb begin
            state_d     = state_q;
            db_d        = db_q;
            tcnt_d      = tcnt_q;
            age_d       = age_q;
            rcnt_d      = rcnt_q;
            long_done_d = long_done_q;
            pressed_d   = pressed_q;
            pp_d        = 1'b0;
            rp_d        = 1'b0;
            rep_d       = 1'b0;
            lp_d        = 1'b0;
            toggle      = 1'b0;
            if (sample_tick) begin
                if (samp == pressed_q) begin
                    db_d = '0;
                end else if (db_q == DBW'(DB_SAMPLES - 1)) begin
                    db_d      = '0;
                    pressed_d = ~pressed_q;
                    toggle    = 1'b1;
                end else begin
                    db_d = db_q + 1'b1;
                end

                // A release edge overrides any repeat/long event due on the same tick.
                if (toggle) begin
                    pp_d        = ~pressed_q;
                    rp_d        = pressed_q;
                    state_d     = pressed_q ? StIdle : StDelay;
                    tcnt_d      = '0;
                    age_d       = '0;
                    rcnt_d      = '0;
                    long_done_d = 1'b0;
                end else if (state_q != StIdle) begin
                    if (age_q != TW'(LONG_TICKS)) age_d = age_q + 1'b1;
                    if (age_q == TW'(LONG_TICKS - 1) && !long_done_q) begin
                        lp_d        = 1'b1;
                        long_done_d = 1'b1;
                    end
                    tcnt_d = tnext;
                    case (state_q)
                        StDelay: begin
                            if (tnext == TW'(DELAY_TICKS)) begin
                                rep_d   = 1'b1;
                                tcnt_d  = '0;
                                rcnt_d  = RW'(1);
                                state_d = (FAST_AFTER == 1) ? StFast : StSlow;
                            end
                        end
                        StSlow: begin
                            if (tnext == TW'(SLOW_TICKS)) begin
                                rep_d  = 1'b1;
                                tcnt_d = '0;
                                rcnt_d = rnext;
                                if (rnext == RW'(FAST_AFTER)) state_d = StFast;
                            end
                        end
                        StFast: begin
                            if (tnext == TW'(FAST_TICKS)) begin
                                rep_d  = 1'b1;
                                tcnt_d = '0;
                                if (rcnt_q != '1) rcnt_d = rnext;
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q     <= StIdle;
                db_q        <= '0;
                tcnt_q      <= '0;
                age_q       <= '0;
                rcnt_q      <= '0;
                long_done_q <= 1'b0;
                pressed_q   <= 1'b0;
                pp_q        <= 1'b0;
                rp_q        <= 1'b0;
                rep_q       <= 1'b0;
                lp_q        <= 1'b0;
            end else begin
                state_q     <= state_d;
                db_q        <= db_d;
                tcnt_q      <= tcnt_d;
                age_q       <= age_d;
                rcnt_q      <= rcnt_d;
                long_done_q <= long_done_d;
                pressed_q   <= pressed_d;
                pp_q        <= pp_d;
                rp_q        <= rp_d;
                rep_q       <= rep_d;
                lp_q        <= lp_d;
            end
        end

        assign pressed_nx[i]    = pressed_d;
        assign pressed[i]       = pressed_q;
        assign press_pulse[i]   = pp_q;
        assign release_pulse[i] = rp_q;
        assign repeat_pulse[i]  = rep_q;
        assign long_pulse[i]    = lp_q;
    end

endmodule

// File: tb/tb_button_repeat_n.sv
// Scoreboard bench for button_repeat_n: expected per-cycle pulse trains are queued
// relative to the press tick and compared cycle by cycle on the falling clock edge.
module tb_button_repeat_n;

    localparam int unsigned NB = 3;
    localparam int DIV = 10;
    localparam int DB  = 3;
    localparam int DLY = 4;
    localparam int SLW = 2;
    localparam int FA  = 2;
    localparam int FST = 1;
    localparam int LNG = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_n = '1;
    logic [NB-1:0] pressed, press_pulse, release_pulse, repeat_pulse, long_pulse;
    logic          any_pressed;

    typedef struct {
        int          off;
        logic [NB-1:0] pp;
        logic [NB-1:0] rp;
        logic [NB-1:0] rep;
        logic [NB-1:0] lp;
    } ev_t;

    ev_t exp_q[$];
    int  n_total = 0;
    int  n_bad   = 0;

    button_repeat_n #(
        .N_BTN(NB), .CLK_HZ(100), .SAMPLE_HZ(10), .DB_SAMPLES(DB), .DELAY_TICKS(DLY),
        .SLOW_TICKS(SLW), .FAST_AFTER(FA), .FAST_TICKS(FST), .LONG_TICKS(LNG)
    ) dut (
        .clk(clk), .rst(rst), .btn_n(btn_n), .pressed(pressed), .press_pulse(press_pulse),
        .release_pulse(release_pulse), .repeat_pulse(repeat_pulse), .long_pulse(long_pulse),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic logic [31:0] out_vec();
        return {16'h0, pressed, press_pulse, release_pulse, repeat_pulse, long_pulse, any_pressed};
    endfunction

    function automatic bit rep_due(input int k);
        int slow_end;
        slow_end = DLY + SLW * (FA - 1);
        if (k == DLY) return 1'b1;
        if (k > DLY && k <= slow_end) return ((k - DLY) % SLW) == 0;
        if (k > slow_end) return ((k - slow_end) % FST) == 0;
        return 1'b0;
    endfunction

    task automatic push_ev(input int off, input logic [NB-1:0] pp, input logic [NB-1:0] rp,
                           input logic [NB-1:0] rep, input logic [NB-1:0] lp);
        ev_t e;
        e.off = off; e.pp = pp; e.rp = rp; e.rep = rep; e.lp = lp;
        exp_q.push_back(e);
    endtask

    // Expected train for a held press released at tick rel_tick, up to cycle max_c.
    task automatic gen_expect(input logic [NB-1:0] mask, input int rel_tick, input int max_c);
        for (int k = 0; k * DIV < max_c; k++) begin
            if (k == 0) begin
                push_ev(0, mask, '0, '0, '0);
            end else if (k == rel_tick) begin
                push_ev(k * DIV, '0, mask, '0, '0);
                break;
            end else if (rep_due(k) || k == LNG) begin
                push_ev(k * DIV, '0, '0, rep_due(k) ? mask : '0, (k == LNG) ? mask : '0);
            end
        end
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        btn_n = '1;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", out_vec(), 32'h0);
        rst = 1'b0;
    endtask

    task automatic wait_press(input string tag);
        bit found = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (press_pulse != '0) begin
                found = 1'b1;
                break;
            end
        end
        check_val({tag, "_press_seen"}, 32'(found), 32'h1);
    endtask

    // Compares every cycle of the window; releases mask at the falling edge of cycle rel_c.
    task automatic check_window(input string tag, input logic [NB-1:0] mask, input int n_cyc,
                                input int rel_c);
        logic [NB-1:0] epress = '0;
        logic [NB-1:0] pp, rp, rep, lp;
        for (int c = 0; c < n_cyc; c++) begin
            if (c > 0) @(negedge clk);
            pp = '0; rp = '0; rep = '0; lp = '0;
            while (exp_q.size() > 0 && exp_q[0].off == c) begin
                ev_t e;
                e = exp_q.pop_front();
                pp |= e.pp; rp |= e.rp; rep |= e.rep; lp |= e.lp;
            end
            epress = (epress | pp) & ~rp;
            check_val($sformatf("%s_c%0d", tag, c), out_vec(),
                      {16'h0, epress, pp, rp, rep, lp, |epress});
            if (c == rel_c) btn_n = btn_n | mask;
        end
        check_val({tag, "_queue_drained"}, 32'(exp_q.size()), 32'h0);
        exp_q.delete();
    endtask

    task automatic run_press(input string tag, input logic [NB-1:0] mask, input int rel_c,
                             input int n_cyc);
        do_reset();
        repeat (7) @(negedge clk);
        btn_n = ~mask;
        gen_expect(mask, rel_c / DIV + DB, n_cyc);
        wait_press(tag);
        check_window(tag, mask, n_cyc, rel_c);
        btn_n = '1;
    endtask

    initial begin
        // Long hold: delay, slow, fast repeats and a single long event; release at T+18.
        run_press("hold", 3'b001, 150, 190);

        // Bouncing input alternates every sample and never debounces.
        do_reset();
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            check_val($sformatf("bounce_c%0d", c), out_vec(), 32'h0);
            if (c % DIV == 0) btn_n[1] = ~btn_n[1];
        end
        btn_n = '1;

        // Release at T+5: one repeat, no long.
        run_press("short", 3'b010, 20, 70);
        // Release lands at T+6, exactly when a slow repeat would be due.
        run_press("race", 3'b001, 30, 70);
        // All channels together.
        run_press("all", 3'b111, 50, 90);

        // Reset at T+5 with the button still held.
        do_reset();
        repeat (7) @(negedge clk);
        btn_n = 3'b110;
        gen_expect(3'b001, 100, 51);
        wait_press("rst");
        check_window("rst", 3'b001, 51, -1);
        rst = 1'b1;
        #1;
        check_val("rst_async_clear", out_vec(), 32'h0);
        repeat (2) @(negedge clk);
        check_val("rst_held_clear", out_vec(), 32'h0);
        rst = 1'b0;
        begin
            int  lat = -1;
            bit  saw_rel = 1'b0;
            for (int n = 1; n <= 60; n++) begin
                @(negedge clk);
                if (release_pulse != '0) saw_rel = 1'b1;
                if (press_pulse != '0) begin
                    lat = n;
                    break;
                end
            end
            check_val("rst_repress_latency", 32'(lat), 32'(DB * DIV));
            check_val("rst_no_release", 32'(saw_rel), 32'h0);
            check_val("rst_repress_mask", 32'(press_pulse), 32'h1);
        end
        btn_n = '1;

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/button_repeat_n.md
BUTTON_REPEAT_N -- requirements
Module: button_repeat_n

Parameters
REQ-001 N_BTN, default 7, number of independent button channels (1..32).
REQ-002 CLK_HZ, default 100_000_000, clk frequency in Hz.
REQ-003 SAMPLE_HZ, default 1000, debounce and timing sample rate; one sample tick is generated every CLK_HZ/SAMPLE_HZ clk cycles.
REQ-004 DB_SAMPLES, default 4, number of consecutive equal samples (>=1) needed to change a debounced level.
REQ-005 DELAY_TICKS, default 400, sample ticks from press to the first auto-repeat (>=1).
REQ-006 SLOW_TICKS, default 100, sample ticks between slow repeats (>=1).
REQ-007 FAST_AFTER, default 8, number of slow-phase repeats, counting the first, before switching to fast phase (>=1).
REQ-008 FAST_TICKS, default 25, sample ticks between fast repeats (>=1).
REQ-009 LONG_TICKS, default 1000, sample ticks from press to the long-press event (>=1).

Interface
REQ-010 clk  in  1  system clock; all logic is on posedge clk.
REQ-011 rst  in  1  asynchronous active-high reset.
REQ-012 btn_n  in  N_BTN  raw active-low switch inputs, asynchronous to clk.
REQ-013 pressed  out  N_BTN  debounced level, active-high.
REQ-014 press_pulse  out  N_BTN  one-clk pulse on each debounced press.
REQ-015 release_pulse  out  N_BTN  one-clk pulse on each debounced release.
REQ-016 repeat_pulse  out  N_BTN  one-clk pulse at each auto-repeat instant; never asserted on the press edge itself.
REQ-017 long_pulse  out  N_BTN  one-clk pulse, at most once per press.
REQ-018 any_pressed  out  1  OR-reduction of pressed, registered.

Function
REQ-019 Each btn_n bit passes through a 2-FF synchroniser before sampling.
REQ-020 One shared tick divider asserts sample_tick for one clk every CLK_HZ/SAMPLE_HZ cycles; all channel state changes occur only on sample_tick cycles.
REQ-021 A debounce counter per channel clears whenever the synchronised sample equals pressed, and increments otherwise. When it reaches DB_SAMPLES, pressed toggles and the counter clears.
REQ-022 press_pulse or release_pulse asserts on the same edge on which pressed toggles, and lasts exactly one clk.
REQ-023 Each channel has a 4-state FSM: IDLE, DELAY, SLOW, FAST, with a tick counter of width $clog2(max of the timing parameters)+1, a repeat counter, and a long_done flag.
REQ-024 In IDLE, a press moves the FSM to DELAY, clears the counters, and clears long_done.
REQ-025 In DELAY, after DELAY_TICKS ticks: issue repeat_pulse, set the repeat count to 1, go to FAST if FAST_AFTER==1, otherwise go to SLOW.
REQ-026 In SLOW, issue repeat_pulse every SLOW_TICKS ticks. On reaching FAST_AFTER repeats, go to FAST.
REQ-027 In FAST, issue repeat_pulse every FAST_TICKS ticks until release. The repeat counter saturates and never wraps.
REQ-028 long_pulse is issued once, LONG_TICKS ticks after press_pulse, in any non-IDLE state. The press-age counter saturates at LONG_TICKS.
REQ-029 Release in any state: the FSM goes to IDLE on the same edge and all counters clear. If release coincides with a due repeat or long event, release wins and neither pulse is issued.
REQ-030 Repeat and long events falling on the same tick both assert in that cycle.
REQ-031 Channels are fully independent. Simultaneous presses, releases and repeats on different channels all appear in the same cycle.

Reset
REQ-032 While rst is high, all outputs are 0, all FSMs are IDLE, and all counters and synchronisers are cleared (synchronisers cleared to released, i.e. 1).
REQ-033 Reset mid-press aborts the press: after rst falls, a still-held button produces a new press_pulse after synchroniser plus DB_SAMPLES latency, with no release_pulse first.

Verification
Bench parameters: CLK_HZ=100, SAMPLE_HZ=10, DB_SAMPLES=3, DELAY_TICKS=4, SLOW_TICKS=2, FAST_AFTER=2, FAST_TICKS=1, LONG_TICKS=10, N_BTN=3. Tick T is the tick carrying press_pulse.
REQ-034 Hold btn_n[0]=0 for 15 ticks -> press_pulse at T; repeat_pulse at T+4, T+6, T+7, T+8, ...; long_pulse once at T+10.
REQ-035 Toggle btn_n[1] every sample for 10 ticks -> pressed stays 0 and no pulses occur.
REQ-036 Hold for 5 ticks and release -> exactly one repeat_pulse (at T+4) and one release_pulse; no long_pulse.
REQ-037 Release timed so the debounced release lands at T+6 -> release_pulse only, no repeat_pulse at T+6.
REQ-038 Press all 3 channels in the same cycle -> identical, cycle-aligned pulse trains on all channels, and any_pressed=1.
REQ-039 Assert rst at T+5 with the button held, then deassert -> all outputs 0 immediately; a fresh press_pulse follows after 3 ticks plus synchroniser latency.
